// File: rtl/spike_encoder.sv
// Temporal spike encoder: buffers one frame of per-channel spike times and,
// on each gamma-start pulse, emits PW-wide pulses delayed by value+1 cycles.
module spike_encoder #(
  parameter int unsigned P    = 4,
  parameter int unsigned WRES = 3,
  parameter int unsigned PW   = 8,
  parameter int unsigned CW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [P*WRES-1:0] in_values,
  input  logic [P-1:0]      in_mask,
  output logic [P-1:0]      output_spikes,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [CW-1:0]     empty_waves
);

  localparam int unsigned T_END  = (1 << WRES) + PW - 1;
  localparam int unsigned TW_RAW = $clog2(T_END + 1);
  localparam int unsigned TW     = (TW_RAW > WRES + 1) ? TW_RAW : WRES + 1;
  localparam logic [TW-1:0] T_LAST = TW'(T_END);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]        state, state_n;
  logic [TW-1:0]     t, t_n;
  logic [P*WRES-1:0] pend_vals, pend_vals_n, act_vals, act_vals_n;
  logic [P-1:0]      pend_mask, pend_mask_n, act_mask, act_mask_n;
  logic              pend_full, pend_full_n;
  logic [CW-1:0]     ew_n;
  logic [P-1:0]      spikes_n;
  logic              frame_done_n, overrun_n;
  logic [TW:0]       lo, hi, t_ext;

  assign in_ready = ~pend_full;
  assign busy     = (state == EMIT);

  always_comb begin
    state_n     = state;
    t_n         = t;
    pend_vals_n = pend_vals;
    pend_mask_n = pend_mask;
    pend_full_n = pend_full;
    act_vals_n  = act_vals;
    act_mask_n  = act_mask;
    ew_n        = empty_waves;
    overrun_n   = grst && (state == EMIT);

    if (state == EMIT) begin
      if (t == T_LAST) begin
        state_n = IDLE;
        t_n     = '0;
      end else begin
        t_n = t + 1'b1;
      end
    end

    // A gamma start decides from the pending state at this edge, so a frame
    // accepted in the same cycle lands in pending and waits for the next wave.
    if (grst) begin
      t_n = '0;
      if (pend_full) begin
        act_vals_n  = pend_vals;
        act_mask_n  = pend_mask;
        pend_full_n = 1'b0;
        state_n     = EMIT;
      end else begin
        state_n = IDLE;
        if (empty_waves != '1) ew_n = empty_waves + 1'b1;
      end
    end

    if (in_valid && !pend_full) begin
      pend_vals_n = in_values;
      pend_mask_n = in_mask;
      pend_full_n = 1'b1;
    end
  end

  // Outputs are registered from next-state values so each flop shows the
  // current cycle's wave position with no input-to-output path.
  always_comb begin
    spikes_n = '0;
    lo       = '0;
    hi       = '0;
    t_ext    = {1'b0, t_n};
    for (int unsigned i = 0; i < P; i++) begin
      lo = (TW+1)'(act_vals_n[i*WRES +: WRES]) + (TW+1)'(1);
      hi = lo + (TW+1)'(PW - 1);
      spikes_n[i] = (state_n == EMIT) && act_mask_n[i] && (t_ext >= lo) && (t_ext <= hi);
    end
    frame_done_n = (state_n == EMIT) && (t_n == T_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      t             <= '0;
      pend_vals     <= '0;
      pend_mask     <= '0;
      pend_full     <= 1'b0;
      act_vals      <= '0;
      act_mask      <= '0;
      output_spikes <= '0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      empty_waves   <= '0;
    end else begin
      state         <= state_n;
      t             <= t_n;
      pend_vals     <= pend_vals_n;
      pend_mask     <= pend_mask_n;
      pend_full     <= pend_full_n;
      act_vals      <= act_vals_n;
      act_mask      <= act_mask_n;
      output_spikes <= spikes_n;
      frame_done    <= frame_done_n;
      overrun       <= overrun_n;
      empty_waves   <= ew_n;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: directed steps push expected outputs,
// a negedge monitor pops and compares them.
module tb_spike_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        grst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [11:0] in_values;
  logic [3:0]  in_mask;
  logic [3:0]  output_spikes, output_spikes2;
  logic        busy, frame_done, overrun;
  logic        busy2, frame_done2, overrun2;
  logic [7:0]  empty_waves;
  logic [1:0]  empty_waves2;
  logic        zero = 1'b0;

  always #5 clk = ~clk;

  spike_encoder #(.P(4), .WRES(3), .PW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
    .in_values(in_values), .in_mask(in_mask), .output_spikes(output_spikes),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .empty_waves(empty_waves)
  );

  // Never fed a frame: every grst is an empty wave, exercising saturation.
  spike_encoder #(.P(4), .WRES(3), .PW(8), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .grst(grst), .in_valid(zero), .in_ready(in_ready2),
    .in_values(in_values), .in_mask(in_mask), .output_spikes(output_spikes2),
    .busy(busy2), .frame_done(frame_done2), .overrun(overrun2), .empty_waves(empty_waves2)
  );

  typedef struct packed {
    logic [3:0] spk;
    logic       busy;
    logic       fd;
    logic       ov;
    logic       rdy;
    logic [7:0] ew;
    logic [1:0] ew2;
    logic [3:0] spk2;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_ew = 0;
  int    n_grst = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string tg;
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      a  = '{spk: output_spikes, busy: busy, fd: frame_done, ov: overrun,
             rdy: in_ready, ew: empty_waves, ew2: empty_waves2, spk2: output_spikes2};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got spk=%b busy=%b fd=%b ov=%b rdy=%b ew=%0d ew2=%0d spk2=%b, exp spk=%b busy=%b fd=%b ov=%b rdy=%b ew=%0d ew2=%0d spk2=%b",
                 tg, a.spk, a.busy, a.fd, a.ov, a.rdy, a.ew, a.ew2, a.spk2,
                 e.spk, e.busy, e.fd, e.ov, e.rdy, e.ew, e.ew2, e.spk2);
      end
    end
  end

  function automatic logic [11:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Pulse on channel i when mask is set and value+1 <= t <= value+8.
  function automatic logic [3:0] wave_exp(input logic [11:0] vals, input logic [3:0] mask, input int t);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'(vals[i*3 +: 3]);
      r[i] = mask[i] && (t >= v + 1) && (t <= v + 8);
    end
    return r;
  endfunction

  task automatic step(input logic g, input logic v, input logic [11:0] vals, input logic [3:0] mask,
                      input logic [3:0] e_spk, input logic e_busy, input logic e_fd,
                      input logic e_ov, input logic e_rdy, input string tag);
    obs_t e;
    grst      = g;
    in_valid  = v;
    in_values = vals;
    in_mask   = mask;
    @(posedge clk);
    #1;
    if (g && !rst) n_grst++;
    e = '{spk: e_spk, busy: e_busy, fd: e_fd, ov: e_ov, rdy: e_rdy,
          ew: 8'(exp_ew), ew2: (n_grst >= 3) ? 2'd3 : 2'(n_grst), spk2: 4'b0000};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    grst     = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [11:0] vals, input logic [3:0] mask, input string tag);
    step(1'b0, 1'b1, vals, mask, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic wave_tail(input logic [11:0] vals, input logic [3:0] mask, input string tag);
    for (int t = 1; t <= 15; t++)
      step(1'b0, 1'b0, '0, '0, wave_exp(vals, mask, t), 1'b1, (t == 15), 1'b0, 1'b1, tag);
    step(1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_end"});
  endtask

  task automatic run_wave(input logic [11:0] vals, input logic [3:0] mask, input string tag);
    step(1'b1, 1'b0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, {tag, "_start"});
    wave_tail(vals, mask, tag);
  endtask

  initial begin
    logic [11:0] va, vb, vc, vd, ve, vf;
    rst = 1'b1; grst = 1'b0; in_valid = 1'b0; in_values = '0; in_mask = '0;
    step(1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    rst = 1'b0;

    // Values {0,3,7,5}, all channels
    va = pack(0, 3, 7, 5);
    load(va, 4'b1111, "load_basic");
    run_wave(va, 4'b1111, "basic");

    // Masked channels
    vb = pack(2, 2, 2, 2);
    load(vb, 4'b0101, "load_mask");
    run_wave(vb, 4'b0101, "mask");

    // Empty waves; second instance saturates at 3
    for (int k = 0; k < 6; k++) begin
      exp_ew++;
      step(1'b1, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "empty_wave");
    end

    // Abort: A running, B loaded at t=2, grst during t=10
    va = pack(1, 0, 6, 4);
    vb = pack(7, 2, 0, 5);
    load(va, 4'b1111, "load_a");
    step(1'b1, 1'b0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, "a_start");
    for (int t = 1; t <= 10; t++)
      step(1'b0, (t == 3), vb, 4'b1011, wave_exp(va, 4'b1111, t), 1'b1, 1'b0, 1'b0, (t < 3), "a_run");
    step(1'b1, 1'b0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, "abort_b_start");
    wave_tail(vb, 4'b1011, "b_run");

    // Held valid against full pending does not overwrite
    vc = pack(4, 1, 3, 6);
    vd = pack(0, 0, 0, 0);
    load(vc, 4'b1110, "load_c");
    step(1'b0, 1'b1, vd, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "hold_full");
    step(1'b0, 1'b1, vd, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "hold_full");
    run_wave(vc, 4'b1110, "c_run");

    // grst with same-cycle load: empty wave now, frame on next grst
    ve = pack(5, 7, 1, 2);
    exp_ew++;
    step(1'b1, 1'b1, ve, 4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "grst_with_load");
    run_wave(ve, 4'b1101, "e_run");

    // Reset mid-wave with a frame pending
    vf = pack(0, 1, 2, 3);
    load(vf, 4'b1111, "load_f");
    step(1'b1, 1'b0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, "f_start");
    for (int t = 1; t <= 5; t++)
      step(1'b0, (t == 1), vc, 4'b1111, wave_exp(vf, 4'b1111, t), 1'b1, 1'b0, 1'b0, 1'b0, "f_run");
    rst = 1'b1;
    exp_ew = 0;
    n_grst = 0;
    step(1'b1, 1'b1, vd, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mid");
    rst = 1'b0;
    step(1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst");
    exp_ew = 1;
    step(1'b1, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "pending_cleared");

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding, exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter P, default 4: number of spike channels, one per column input.
REQ-002 Parameter WRES, default 3: bits per encoded value; latest spike slot is (1<<WRES)-1.
REQ-003 Parameter PW, default 8: output pulse width in clk cycles.
REQ-004 Parameter CW, default 8: width of the empty-wave counter.
REQ-005 clk  input  1  unit clock, all logic on posedge; single clock domain.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 grst  input  1  one-cycle gamma-start pulse; starts a computational wave.
REQ-008 in_valid  input  1  frame offered.
REQ-009 in_ready  output  1  encoder can accept a frame.
REQ-010 in_values  input  P x WRES  per-channel spike time (0..(1<<WRES)-1).
REQ-011 in_mask  input  P  1 = channel spikes this wave, 0 = no spike.
REQ-012 output_spikes  output  P  temporally encoded pulses to the column's input_spikes.
REQ-013 busy  output  1  a wave is being emitted.
REQ-014 frame_done  output  1  one-cycle pulse in the last cycle of a wave.
REQ-015 overrun  output  1  one-cycle pulse when grst arrives while busy.
REQ-016 empty_waves  output  CW  saturating count of grst pulses with no pending frame.

Function
REQ-017 One-entry pending buffer (values + mask); in_ready SHALL equal NOT pending_full.
REQ-018 Transfer on in_valid AND in_ready at a posedge; pending_full set next cycle; in_values/in_mask ignored otherwise.
REQ-019 States IDLE and EMIT; wave counter t, WRES+1 bits minimum, T_END = (1<<WRES)+PW-1 (15 at defaults).
REQ-020 grst with pending_full (either state): copy pending to active registers, clear pending_full, t <= 0, state <= EMIT.
REQ-021 grst with pending empty: state <= IDLE, empty_waves += 1 (saturates at all-ones), no pulses this wave.
REQ-022 grst while EMIT: current wave aborted, overrun pulses in the following cycle, then REQ-020/021 applies.
REQ-023 Same-cycle grst and accepted transfer (pending empty): new frame goes to pending only, not into the starting wave; no bypass.
REQ-024 In EMIT, t increments by 1 per cycle; at t == T_END, frame_done = 1 that cycle and state <= IDLE next.
REQ-025 output_spikes[i] SHALL be 1 exactly in EMIT cycles with mask[i]=1 and v[i]+1 <= t <= v[i]+PW: a PW-wide pulse starting v[i]+1 cycles after the grst edge.
REQ-026 Value 0 SHALL still start one cycle after the wave start, per the column's earliest-spike rule; value (1<<WRES)-1 pulse ends at t = T_END.
REQ-027 output_spikes, busy, frame_done, overrun SHALL be driven from flops (no combinational path from inputs).
REQ-028 busy = 1 iff state == EMIT; output_spikes = 0 in IDLE.
REQ-029 An abort (REQ-022) SHALL drop any in-flight pulse in the same cycle the new wave starts; no pulse merges across waves.

Reset
REQ-030 rst high at a posedge: state IDLE, t = 0, pending_full = 0, in_ready = 1, output_spikes = 0, busy = 0, frame_done = 0, overrun = 0, empty_waves = 0.
REQ-031 rst SHALL override grst and in_valid in the same cycle; rst mid-wave cuts pulses the next cycle with no frame_done.

Verification
REQ-032 Load values {0,3,7,5}, mask 1111, then grst -> ch0 high t=1..8, ch1 t=4..11, ch2 t=8..15, ch3 t=6..13; frame_done at t=15; busy falls at t=16.
REQ-033 mask 0101 with values {2,2,2,2} -> only ch0 and ch2 pulse at t=3..10; ch1 and ch3 stay 0 for the whole wave.
REQ-034 Three grst pulses with no frame loaded -> empty_waves = 3, output_spikes stay 0; with CW=2, six pulses -> saturates at 3.
REQ-035 Frame A pending, grst, then frame B loaded at t=2, grst at t=10 -> overrun pulses once, A's pulses end, B starts at t=0, in_ready returns to 1.
REQ-036 in_valid held with pending full -> in_ready = 0, no overwrite; grst and in_valid in same cycle with pending empty -> empty wave, frame held, emitted on the next grst.
REQ-037 rst asserted at t=5 of a wave -> all outputs 0 next cycle, pending cleared, in_ready = 1, no frame_done.
